// File: rtl/frame_scanner.sv
// Snapshots game-core object positions and score, then streams one tile code per
// playfield cell (row-major) followed by three score-digit HUD tiles over valid/ready.
module frame_scanner #(
  parameter int COLS = 20,
  parameter int ROWS = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_req,
  input  logic [4:0] player_x,
  input  logic [3:0] player_y,
  input  logic [4:0] bullet_x,
  input  logic [3:0] bullet_y,
  input  logic       bullet_active,
  input  logic [4:0] enemy0_x,
  input  logic [3:0] enemy0_y,
  input  logic       enemy0_active,
  input  logic [4:0] enemy1_x,
  input  logic [3:0] enemy1_y,
  input  logic       enemy1_active,
  input  logic [4:0] enemy2_x,
  input  logic [3:0] enemy2_y,
  input  logic       enemy2_active,
  input  logic [7:0] score,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] out_tile,
  output logic [4:0] out_x,
  output logic [3:0] out_y,
  output logic       out_last,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_HUD  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [4:0] X_LAST = 5'(COLS - 1);
  localparam logic [3:0] Y_LAST = 4'(ROWS - 1);
  localparam logic [3:0] Y_HUD  = 4'(ROWS);

  logic [1:0] state_reg;
  logic [4:0] x_reg;
  logic [3:0] y_reg;
  logic       busy_reg;

  logic [4:0] ply_x_reg, blt_x_reg;
  logic [3:0] ply_y_reg, blt_y_reg;
  logic       blt_act_reg;
  logic [1:0] dig_h_reg;
  logic [3:0] dig_t_reg, dig_u_reg;

  logic [4:0] en_x_in [3];
  logic [3:0] en_y_in [3];
  logic [2:0] en_act_in;
  logic [2:0] en_hit;

  logic       accept;
  logic       xfer;
  logic [7:0] hund_full;
  logic [7:0] rem_full;
  logic       bullet_hit;
  logic [4:0] tile_next;

  assign accept = (state_reg == S_IDLE) && frame_req;
  assign xfer   = out_valid && out_ready;

  assign en_x_in   = '{enemy0_x, enemy1_x, enemy2_x};
  assign en_y_in   = '{enemy0_y, enemy1_y, enemy2_y};
  assign en_act_in = {enemy2_active, enemy1_active, enemy0_active};

  // Digits are split at snapshot time so the HUD beats need no divider in the output path.
  assign hund_full = score / 8'd100;
  assign rem_full  = score % 8'd100;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_enemy
      logic [4:0] ex_reg;
      logic [3:0] ey_reg;
      logic       eact_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ex_reg   <= '0;
          ey_reg   <= '0;
          eact_reg <= 1'b0;
        end else if (accept) begin
          ex_reg   <= en_x_in[gi];
          ey_reg   <= en_y_in[gi];
          eact_reg <= en_act_in[gi];
        end
      end

      assign en_hit[gi] = eact_reg && (ex_reg == x_reg) && (ey_reg == y_reg);
    end
  endgenerate

  assign bullet_hit = blt_act_reg && (blt_x_reg == x_reg) && (blt_y_reg == y_reg);

  always_comb begin
    tile_next = 5'd0;
    if (state_reg == S_SCAN) begin
      if (bullet_hit && (|en_hit))     tile_next = 5'd4;
      else if (bullet_hit)             tile_next = 5'd3;
      else if (|en_hit)                tile_next = 5'd2;
      else if ((ply_x_reg == x_reg) && (ply_y_reg == y_reg)) tile_next = 5'd1;
    end else if (state_reg == S_HUD) begin
      case (x_reg)
        5'd0:    tile_next = 5'd16 + {3'd0, dig_h_reg};
        5'd1:    tile_next = 5'd16 + {1'b0, dig_t_reg};
        default: tile_next = 5'd16 + {1'b0, dig_u_reg};
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ply_x_reg   <= '0;
      ply_y_reg   <= '0;
      blt_x_reg   <= '0;
      blt_y_reg   <= '0;
      blt_act_reg <= 1'b0;
      dig_h_reg   <= '0;
      dig_t_reg   <= '0;
      dig_u_reg   <= '0;
    end else if (accept) begin
      ply_x_reg   <= player_x;
      ply_y_reg   <= player_y;
      blt_x_reg   <= bullet_x;
      blt_y_reg   <= bullet_y;
      blt_act_reg <= bullet_active;
      dig_h_reg   <= hund_full[1:0];
      dig_t_reg   <= 4'(rem_full / 8'd10);
      dig_u_reg   <= 4'(rem_full % 8'd10);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      x_reg     <= '0;
      y_reg     <= '0;
      busy_reg  <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: if (frame_req) begin
          state_reg <= S_SCAN;
          x_reg     <= '0;
          y_reg     <= '0;
          busy_reg  <= 1'b1;
        end
        S_SCAN: if (xfer) begin
          if (x_reg == X_LAST) begin
            x_reg <= '0;
            if (y_reg == Y_LAST) begin
              y_reg     <= Y_HUD;
              state_reg <= S_HUD;
            end else begin
              y_reg <= y_reg + 4'd1;
            end
          end else begin
            x_reg <= x_reg + 5'd1;
          end
        end
        S_HUD: if (xfer) begin
          if (x_reg == 5'd2) begin
            state_reg <= S_DONE;
            busy_reg  <= 1'b0;
          end else begin
            x_reg <= x_reg + 5'd1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign out_valid  = (state_reg == S_SCAN) || (state_reg == S_HUD);
  assign out_tile   = tile_next;
  assign out_x      = x_reg;
  assign out_y      = y_reg;
  assign out_last   = (state_reg == S_HUD) && (x_reg == 5'd2);
  assign busy       = busy_reg;
  assign frame_done = (state_reg == S_DONE);

endmodule

// File: tb/tb_frame_scanner.sv
// Directed bench for frame_scanner: a reference model pushes every expected beat into a
// scoreboard queue at frame request; beats are popped and compared as they transfer.
module tb_frame_scanner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_req = 1'b0;
  logic [4:0] player_x = '0, bullet_x = '0, enemy0_x = '0, enemy1_x = '0, enemy2_x = '0;
  logic [3:0] player_y = '0, bullet_y = '0, enemy0_y = '0, enemy1_y = '0, enemy2_y = '0;
  logic       bullet_active = 1'b0, enemy0_active = 1'b0, enemy1_active = 1'b0, enemy2_active = 1'b0;
  logic [7:0] score = '0;
  logic       out_valid, out_ready = 1'b0;
  logic [4:0] out_tile, out_x;
  logic [3:0] out_y;
  logic       out_last, busy, frame_done;

  int total = 0;
  int bad = 0;
  logic [14:0] sb[$];
  logic [14:0] beat_log[$];

  frame_scanner #(.COLS(20), .ROWS(15)) dut (
    .clk(clk), .rst_n(rst_n), .frame_req(frame_req),
    .player_x(player_x), .player_y(player_y),
    .bullet_x(bullet_x), .bullet_y(bullet_y), .bullet_active(bullet_active),
    .enemy0_x(enemy0_x), .enemy0_y(enemy0_y), .enemy0_active(enemy0_active),
    .enemy1_x(enemy1_x), .enemy1_y(enemy1_y), .enemy1_active(enemy1_active),
    .enemy2_x(enemy2_x), .enemy2_y(enemy2_y), .enemy2_active(enemy2_active),
    .score(score), .out_valid(out_valid), .out_ready(out_ready),
    .out_tile(out_tile), .out_x(out_x), .out_y(out_y), .out_last(out_last),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] model_tile(input int x, input int y);
    logic b, e;
    b = bullet_active && (int'(bullet_x) == x) && (int'(bullet_y) == y);
    e = (enemy0_active && int'(enemy0_x) == x && int'(enemy0_y) == y) ||
        (enemy1_active && int'(enemy1_x) == x && int'(enemy1_y) == y) ||
        (enemy2_active && int'(enemy2_x) == x && int'(enemy2_y) == y);
    if (b && e) return 5'd4;
    if (b) return 5'd3;
    if (e) return 5'd2;
    if (int'(player_x) == x && int'(player_y) == y) return 5'd1;
    return 5'd0;
  endfunction

  // Expected beat packing: {tile, x, y, last}
  task automatic build_expected();
    int s;
    sb.delete();
    for (int y = 0; y < 15; y++)
      for (int x = 0; x < 20; x++)
        sb.push_back({model_tile(x, y), 5'(x), 4'(y), 1'b0});
    s = int'(score);
    sb.push_back({5'(16 + s / 100), 5'd0, 4'd15, 1'b0});
    sb.push_back({5'(16 + (s % 100) / 10), 5'd1, 4'd15, 1'b0});
    sb.push_back({5'(16 + s % 10), 5'd2, 4'd15, 1'b1});
  endtask

  task automatic run_frame(input string name, input bit rand_ready, input bit mid_req, input bit do_reset);
    logic [14:0] cur, held, exp;
    bit prev_stall = 0;
    int beats = 0, done_cnt = 0, done_k = 0;
    build_expected();
    beat_log.delete();
    @(negedge clk);
    frame_req = 1'b1;
    @(negedge clk);
    frame_req = 1'b0;
    for (int k = 1; k < 3000; k++) begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (k == 1) begin
        check({name, " busy_at_accept"}, busy, 1);
        check({name, " valid_at_accept"}, out_valid, 1);
      end
      if (mid_req && k == 50) begin
        enemy0_x = enemy0_x + 5'd1;
        frame_req = 1'b1;
      end
      if (mid_req && k == 51) frame_req = 1'b0;
      if (do_reset && k == 100) begin
        rst_n = 1'b0;
        #1;
        check("reset_outputs", {out_valid, out_tile, out_x, out_y, out_last, busy, frame_done}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          check("no_beat_after_reset", {out_valid, frame_done, busy}, 0);
        end
        return;
      end
      cur = {out_tile, out_x, out_y, out_last};
      if (prev_stall) check({name, " stall_stable"}, cur, held);
      prev_stall = out_valid && !out_ready;
      held = cur;
      if (done_k > 0) check({name, " idle_after_done"}, out_valid, 0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check({name, " extra_beat"}, beats, 303);
        end else begin
          exp = sb.pop_front();
          $display("%s beat %0d tile=%0d x=%0d y=%0d last=%0b", name, beats, out_tile, out_x, out_y, out_last);
          check($sformatf("%s beat%0d", name, beats), cur, exp);
        end
        beat_log.push_back(cur);
        beats++;
      end
      if (frame_done) begin
        done_cnt++;
        done_k = k;
        check({name, " busy_at_done"}, busy, 0);
        if (!rand_ready) check({name, " done_cycle"}, k, 304);
      end
      if (done_k > 0 && k >= done_k + 6) break;
      @(negedge clk);
    end
    check({name, " done_count"}, done_cnt, 1);
    check({name, " beat_count"}, beats, 303);
    check({name, " sb_empty"}, sb.size(), 0);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [14:0] ref_log[$];
    repeat (3) @(negedge clk);
    check("reset_state", {out_valid, out_tile, out_x, out_y, out_last, busy, frame_done}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_valid", {out_valid, busy}, 0);

    // Basic frame
    player_x = 10; player_y = 14;
    enemy0_x = 3; enemy0_y = 2; enemy0_active = 1;
    bullet_x = 10; bullet_y = 13; bullet_active = 1;
    score = 8'd207;
    run_frame("basic", 0, 0, 0);
    ref_log = beat_log;
    check("basic b43", ref_log[43], {5'd2, 5'd3, 4'd2, 1'b0});
    check("basic b270", ref_log[270], {5'd3, 5'd10, 4'd13, 1'b0});
    check("basic b290", ref_log[290], {5'd1, 5'd10, 4'd14, 1'b0});
    check("hud207 b300", ref_log[300], {5'd18, 5'd0, 4'd15, 1'b0});
    check("hud207 b301", ref_log[301], {5'd16, 5'd1, 4'd15, 1'b0});
    check("hud207 b302", ref_log[302], {5'd23, 5'd2, 4'd15, 1'b1});

    // Backpressure: same content and order as the ready=1 run
    run_frame("bp", 1, 0, 0);
    for (int i = 0; i < 303; i += 37) check($sformatf("bp_vs_ref%0d", i), beat_log[i], ref_log[i]);

    // Overlap and priority
    enemy0_active = 0;
    enemy1_x = 5; enemy1_y = 5; enemy1_active = 1;
    bullet_x = 5; bullet_y = 5; bullet_active = 1;
    enemy2_x = 0; enemy2_y = 0; enemy2_active = 1;
    player_x = 0; player_y = 0;
    score = 8'd0;
    run_frame("prio", 0, 0, 0);
    check("prio b105", beat_log[105], {5'd4, 5'd5, 4'd5, 1'b0});
    check("prio b0", beat_log[0], {5'd2, 5'd0, 4'd0, 1'b0});
    check("hud0 b300", beat_log[300][14:10], 5'd16);
    enemy1_active = 0;
    run_frame("prio2", 0, 0, 0);
    check("prio2 b105", beat_log[105], {5'd3, 5'd5, 4'd5, 1'b0});

    // Snapshot holds while inputs change; mid-frame request ignored
    enemy0_x = 7; enemy0_y = 9; enemy0_active = 1;
    run_frame("snap", 0, 1, 0);
    check("snap b187", beat_log[187], {5'd2, 5'd7, 4'd9, 1'b0});

    // Reset mid-scan
    run_frame("rst", 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
